min_max_sequencer: RTL

MIN_MAX_SEQUENCER -- requirements
Module: min_max_sequencer

---
 rtl/min_max_pkg.sv | 21 ++
 rtl/seq_watchdog.sv | 38 +++
 rtl/min_max_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max sequencer and the min/max finder it drives.
package min_max_pkg;

  localparam int DATA_W      = 3;
  localparam int TIMEOUT_DEF = 12;

  typedef enum logic [4:0] {
    ST_COLLECT = 5'b00001,
    ST_ISSUE   = 5'b00010,
    ST_WAIT    = 5'b00100,
    ST_ACK     = 5'b01000,
    ST_RESULT  = 5'b10000
  } state_t;

  // The finder guarantees hi >= lo, so a plain modular difference is exact.
  function automatic logic [DATA_W-1:0] data_range(input logic [DATA_W-1:0] hi,
                                                   input logic [DATA_W-1:0] lo);
    return hi - lo;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Done-wait watchdog: counts qualifying cycles and flags the cycle that reaches TIMEOUT.
module seq_watchdog
  import min_max_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Combinational so the owner can leave WAIT on the very cycle the limit is hit.
  assign expired = inc && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/min_max_sequencer.sv
// Gathers sample triples, hands them to an external min/max finder and
// presents max, min and range downstream with a valid/ready handshake.
//
// state   | meaning
// COLLECT | accept three samples into xin, yin, zin
// ISSUE   | one-cycle start pulse to the finder
// WAIT    | wait for Done while the watchdog runs
// ACK     | one-cycle ack pulse to the finder
// RESULT  | hold out_valid until out_ready
module min_max_sequencer
  import min_max_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              start,
  output logic              ack,
  output logic [DATA_W-1:0] xin,
  output logic [DATA_W-1:0] yin,
  output logic [DATA_W-1:0] zin,
  input  logic              Done,
  input  logic [DATA_W-1:0] max,
  input  logic [DATA_W-1:0] min,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_range,
  output logic [7:0]        count,
  output logic              err
);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] xin_q, xin_d, yin_q, yin_d, zin_q, zin_d;
  logic [DATA_W-1:0] out_max_q, out_max_d, out_min_q, out_min_d;
  logic [DATA_W-1:0] out_range_q, out_range_d;
  logic [7:0]        count_q, count_d;
  logic              err_q, err_d;
  logic              timed_out_q, timed_out_d;
  logic              wd_clr, wd_inc, wd_expired;

  assign wd_clr = (state_q != ST_WAIT);
  assign wd_inc = (state_q == ST_WAIT) && !Done;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xin_d       = xin_q;
    yin_d       = yin_q;
    zin_d       = zin_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_range_d = out_range_q;
    count_d     = count_q;
    err_d       = err_q;
    timed_out_d = timed_out_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          unique case (idx_q)
            2'd0:    xin_d = in_data;
            2'd1:    yin_d = in_data;
            default: zin_d = in_data;
          endcase
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = ST_ISSUE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_ISSUE: begin
        timed_out_d = 1'b0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          out_max_d   = max;
          out_min_d   = min;
          out_range_d = data_range(max, min);
          state_d     = ST_ACK;
        end else if (wd_expired) begin
          // Finder is left running; only this sequencer gives up on the triple.
          err_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = timed_out_q ? ST_COLLECT : ST_RESULT;
      end
      ST_RESULT: begin
        if (out_ready) begin
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      idx_q       <= 2'd0;
      xin_q       <= '0;
      yin_q       <= '0;
      zin_q       <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_range_q <= '0;
      count_q     <= 8'd0;
      err_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xin_q       <= xin_d;
      yin_q       <= yin_d;
      zin_q       <= zin_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_range_q <= out_range_d;
      count_q     <= count_d;
      err_q       <= err_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Handshake strobes decode straight from the one-hot state register.
  assign in_ready  = (state_q == ST_COLLECT);
  assign start     = (state_q == ST_ISSUE);
  assign ack       = (state_q == ST_ACK);
  assign out_valid = (state_q == ST_RESULT);
  assign xin       = xin_q;
  assign yin       = yin_q;
  assign zin       = zin_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign out_range = out_range_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule
